// File: rtl/vga_pixel_streamer.sv
// Streams one frame of RGB565 pixels from SRAM to the VGA controller as
// gap-free 24-bit pixels, one per clock, with line and frame markers.
module vga_pixel_streamer #(
  parameter int AW               = 18,
  parameter int DW               = 16,
  parameter int IMAGE_WIDTH      = 320,
  parameter int IMAGE_HEIGHT     = 240,
  parameter int ADDR_ORDER_PIXEL = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic          vgastart,
  output logic          pixel_valid,
  output logic          line_end,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
);

  localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
  localparam logic [AW-1:0] BASE     = AW'(ADDR_ORDER_PIXEL);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t        state, state_next;
  logic [IW-1:0] issue_idx;
  logic          rd_valid;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // DRAIN ends once the SRAM-data stage is empty, i.e. the last pixel is on r/g/b.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (issue_idx == LAST_IDX) state_next = DRAIN;
      DRAIN:   if (!rd_valid) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      READ, DRAIN: busy = 1'b1;
      FIN:         done = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_raddr <= '0;
      issue_idx  <= '0;
    end else if (state == IDLE && start) begin
      sram_raddr <= BASE;
      issue_idx  <= '0;
    end else if (state == READ && issue_idx != LAST_IDX) begin
      sram_raddr <= sram_raddr + AW'(1);
      issue_idx  <= issue_idx + IW'(1);
    end
  end

  // Marks that sram_rdata in this cycle answers an address issued during READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= (state == READ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else if (rd_valid) begin
      pixel_valid <= 1'b1;
      r           <= {sram_rdata[15:11], sram_rdata[15:13]};
      g           <= {sram_rdata[10:5],  sram_rdata[10:9]};
      b           <= {sram_rdata[4:0],   sram_rdata[4:2]};
    end else begin
      pixel_valid <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end
  end

  // col/row describe the pixel currently on r/g/b and advance after it is shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign line_end = pixel_valid && (col == LAST_COL);
  assign vgastart = pixel_valid && (col == '0) && (row == '0);

endmodule

// File: doc/vga_pixel_streamer.md
Name: vga_pixel_streamer

Overview:
Downstream stage of the decompressor. Once the decompressor reports done, this block reads the ordered RGB565 pixel region from SRAM through a read-only port. It streams one expanded 24-bit pixel per clock to the VGA controller interface (vgastart, r, g, b). The stream is gap-free and covers exactly one frame per start.

Parameters:
AW, 18, SRAM address width
DW, 16, SRAM data width; fixed at 16 because the pixel format is RGB565
IMAGE_WIDTH, 320, pixels per line, minimum 1
IMAGE_HEIGHT, 240, lines per frame, minimum 1
ADDR_ORDER_PIXEL, 0, SRAM word address of pixel (0,0); pixels are row-major, one word each

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to stream one frame; sampled only in IDLE
busy  output  1  high from the accepting edge until done is asserted
done  output  1  one-cycle pulse after the last pixel
sram_raddr  output  AW  SRAM read address
sram_rdata  input  DW  SRAM read data; valid one cycle after the address
vgastart  output  1  one-cycle pulse, coincident with pixel 0
pixel_valid  output  1  high while r/g/b carry a frame pixel
line_end  output  1  high with the last pixel of each line
r  output  8  red channel, expanded
g  output  8  green channel, expanded
b  output  8  blue channel, expanded

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of state:
  - state=IDLE;
  - all outputs 0, including sram_raddr, r, g and b;
  - all counters 0.
- States:
  - IDLE: start=1 -> READ; sram_raddr<=ADDR_ORDER_PIXEL; busy<=1.
  - READ: issues one address per cycle. sram_raddr increments by 1 each cycle until it reaches ADDR_ORDER_PIXEL+N-1, where N=IMAGE_WIDTH*IMAGE_HEIGHT. It holds that value afterwards. Once the last address has been issued -> DRAIN.
  - DRAIN: waits for the 2-stage pipeline to empty. After the last pixel has been presented -> FIN.
  - FIN: done=1 and busy=0 for one cycle -> IDLE.
- Read latency: an address present on sram_raddr during cycle k yields sram_rdata during cycle k+1. The block registers the expanded pixel at the end of cycle k+1, so it appears on r/g/b during cycle k+2.
- First-pixel timing: if start is sampled at edge E0, pixel 0 appears on r/g/b in the 3rd cycle after E0. vgastart=1 and pixel_valid=1 in that same cycle.
- Stream continuity: pixels appear in N consecutive cycles with no bubbles, and pixel_valid stays high for exactly N cycles. done pulses in the cycle immediately after the last pixel.
- Pixel expansion, with w=sram_rdata:
  - r={w[15:11],w[15:13]}
  - g={w[10:5],w[10:9]}
  - b={w[4:0],w[4:2]}
  - r/g/b are 0 whenever pixel_valid=0.
- Position tracking:
  - Column counter: 0..IMAGE_WIDTH-1. Row counter: 0..IMAGE_HEIGHT-1. Both are aligned to the output stage.
  - line_end=1 when the column counter equals IMAGE_WIDTH-1 and pixel_valid=1. The column counter then wraps to 0 and the row counter increments.
  - Both counters are 0 again after the frame.
- Address arithmetic is modulo 2^AW. The region must fit; the block does not check this.
- start while busy=1 (READ, DRAIN or FIN) is ignored and has no queuing effect. start in the same cycle as done is also ignored.
- Reset mid-frame aborts immediately. No done pulse is produced, and the next start after reset release begins a full new frame.
- IMAGE_WIDTH=1: line_end=1 on every pixel. N=1: vgastart, pixel_valid and line_end are all high in the single pixel cycle, and done follows in the next cycle.

Test Plan:
- Reset values: hold reset=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; release and idle 5 cycles -> outputs stay 0 with start=0.
- Basic frame: WIDTH=4, HEIGHT=2, base=0x100, SRAM[0x100+i]=16'hF800 for even i and 16'h07E0 for odd i, start pulse at edge E0.
  - Cycle 3 after E0: vgastart=1.
  - 8 consecutive pixels alternate (FF,00,00) and (00,FF,00).
  - line_end high on pixels 3 and 7.
  - done in the cycle after pixel 7.
  - sram_raddr runs 0x100..0x107.
- Expansion: word 16'h841F -> r=8'h84, g=8'h82, b=8'hFF; word 16'h0000 -> (0,0,0) with pixel_valid=1.
- Start while busy: a second start pulse at pixel 2 -> exactly 8 pixels and one done pulse; busy falls once.
- Reset mid-frame: assert reset at pixel 5 -> pixel_valid=0 immediately and no done pulse. A start after release -> a full 8-pixel frame beginning at 0x100.
- Degenerate 1x1 frame, SRAM[base]=16'hFFFF -> one cycle with vgastart=pixel_valid=line_end=1 and r=g=b=8'hFF, then done=1 the next cycle.
